unidade_de_desvio: RTL and testbench
====================================

# unidade_de_desvio

- Branch-resolution unit: the consumer side of the ALU flag path.
- Latches Zero/Overflow/Negative flags into a status register whenever the ALU stage writes them.
- Accepts one conditional-branch request at a time, waits out any in-flight flag-producing operation, and evaluates the 3-bit condition.
- Presents the taken/not-taken decision and target to the fetch stage through a valid/ready handshake.

## Interface
- WIDTH, 32, width of branch target address.
- Clock  in  1  single clock; all state updates on rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Flag_Write  in  1  ALU stage writes flags this cycle.
- Zero_In  in  1  zero flag from ALU.
- Overflow_In  in  1  overflow flag from ALU.
- Negative_In  in  1  sign bit of ALU result.
- Flag_Busy  in  1  a flag-writing ALU op is in flight and not yet written.
- Branch_Valid  in  1  branch request present.
- Branch_Ready  out  1  unit can accept a request.
- Branch_Cond  in  3  condition code.
- Branch_Target  in  WIDTH  target address.
- Flush  in  1  synchronous abort of the request in progress.
- Take_Valid  out  1  decision available.
- Take_Ready  in  1  fetch stage consumes the decision.
- Take_Branch  out  1  1 = branch taken.
- Target_Out  out  WIDTH  captured target.
- Flags  out  3  status register {N,V,Z}.

## Operation
- **Flag register:** on Flag_Write it loads {Negative_In, Overflow_In, Zero_In}. This happens in every state and is independent of the FSM and of Flush.
- **Condition codes:**
  - 000 always
  - 001 EQ (Z)
  - 010 NE (~Z)
  - 011 LT (N^V)
  - 100 GE (~(N^V))
  - 101 VS (V)
  - 110 VC (~V)
  - 111 never
- **FSM:** four states IDLE, WAIT, EVAL, HOLD.
- **IDLE:**
  - Branch_Ready=1.
  - Accept on Branch_Valid&Branch_Ready; capture Branch_Cond and Branch_Target.
  - On accept: go to WAIT if Flag_Busy=1, else EVAL.
- **WAIT:**
  - Branch_Ready=0.
  - Go to EVAL on a cycle with Flag_Write=1, or with Flag_Busy=0 (cancelled op; current flags are used).
- **EVAL:** evaluate the captured condition against the Flags register value present in this cycle. Register Take_Branch and Target_Out, set Take_Valid=1, go to HOLD.
- **HOLD:**
  - Take_Valid, Take_Branch and Target_Out stay stable until Take_Valid&Take_Ready.
  - On that handshake: clear Take_Valid, go to IDLE.
  - No new request is accepted in the same cycle.
- **Flush** in any state except IDLE: next state IDLE, Take_Valid cleared. Take_Branch and Target_Out keep their last values. Flush in IDLE is ignored.
- **Priority:** Flush has priority over every FSM transition.
- **Flag_Write coinciding with accept:** the write lands at the same edge, and EVAL sees the new flags.
- **Flag_Write during HOLD:** updates Flags only; the decision already presented does not change.

## Timing
- **Reset values:**
  - State IDLE.
  - Flags=3'b000.
  - Take_Valid=0, Take_Branch=0, Target_Out=0.
  - Branch_Ready=1 once Reset_n is high.
- **Reset mid-operation:** the request is dropped immediately (asynchronous reset).
- **Latency:** accept at edge k → EVAL during cycle k..k+1 → Take_Valid=1 after edge k+1. This gives 2 cycles from request to decision with no hazard.
- **Hazard case:** Flag_Write at edge j in WAIT → EVAL after j → Take_Valid after edge j+1.
- **Throughput:** at most one branch per 3 cycles.
- **Outputs:** Branch_Ready is a decode of the state. All Take_* outputs are registered. No combinational path from any input to any output.

## Structure
- **Shared package** holds the state enumeration (IDLE/WAIT/EVAL/HOLD) and the 3-bit condition-code constants. The ALU-control decoder uses the same constants.
- **Sub-module avaliador_de_condicao:** combinational; inputs {N,V,Z} and cond, output taken. It is kept separate so it can be reused by a future conditional-move path.

## Test plan
- **Reset:** Reset_n low mid-HOLD → Take_Valid=0, Flags=000, Branch_Ready=1 immediately.
- **EQ taken:**
  - Flag_Write with Z=1.
  - Next cycle: branch cond=001, target=0x0000_0040, Flag_Busy=0.
  - Expect Take_Valid=1 two edges after accept, Take_Branch=1, Target_Out=0x40.
- **Hazard:**
  - Accept cond=011 with Flag_Busy=1 and Flags N=0,V=0.
  - Hold Busy 3 cycles, then Flag_Write N=1,V=0.
  - Expect Take_Branch=1, and Take_Valid to rise exactly 2 edges after the Flag_Write edge.
- **Back-pressure:**
  - Take_Ready=0 for 5 cycles in HOLD while Flag_Write flips Z.
  - Expect Take_* stable and Branch_Ready=0 throughout.
  - Expect Flags updated, and IDLE the cycle after Take_Ready=1.
- **Flush:** Flush during WAIT → IDLE next cycle, no Take_Valid pulse, Flags unchanged.
- **Sweep:** for all 8 cond codes × 8 flag combinations, compare Take_Branch against the condition table above; cond=000 always 1, cond=111 always 0.

Source files
------------

// File: rtl/unidade_de_desvio_pkg.sv
// Shared definitions for the branch-resolution unit: FSM states, condition
// codes and the bit positions of the {N,V,Z} status register.
package unidade_de_desvio_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_EVAL = 2'd2,
      ST_HOLD = 2'd3
   } state_t;

   // Also used by the ALU-control decoder, so the encodings must stay fixed.
   localparam logic [2:0] COND_AL = 3'b000;
   localparam logic [2:0] COND_EQ = 3'b001;
   localparam logic [2:0] COND_NE = 3'b010;
   localparam logic [2:0] COND_LT = 3'b011;
   localparam logic [2:0] COND_GE = 3'b100;
   localparam logic [2:0] COND_VS = 3'b101;
   localparam logic [2:0] COND_VC = 3'b110;
   localparam logic [2:0] COND_NV = 3'b111;

   localparam int FLAG_N = 2;
   localparam int FLAG_V = 1;
   localparam int FLAG_Z = 0;

endpackage

// File: rtl/unidade_de_desvio_avaliador_de_condicao.sv
// Combinational condition evaluator: decides taken/not-taken from {N,V,Z}
// and a 3-bit condition code. Kept standalone for a future conditional-move path.
module avaliador_de_condicao
   import unidade_de_desvio_pkg::*;
(
   input  logic [2:0] flags_i,
   input  logic [2:0] cond_i,
   output logic       taken_o
);

   logic lessThan;
   assign lessThan = flags_i[FLAG_N] ^ flags_i[FLAG_V];

   always_comb begin
      taken_o = 1'b0;
      case (cond_i)
         COND_AL: taken_o = 1'b1;
         COND_EQ: taken_o = flags_i[FLAG_Z];
         COND_NE: taken_o = ~flags_i[FLAG_Z];
         COND_LT: taken_o = lessThan;
         COND_GE: taken_o = ~lessThan;
         COND_VS: taken_o = flags_i[FLAG_V];
         COND_VC: taken_o = ~flags_i[FLAG_V];
         COND_NV: taken_o = 1'b0;
         default: taken_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/unidade_de_desvio.sv
// Branch-resolution unit: latches ALU flags, accepts one branch at a time,
// waits out in-flight flag writers and hands the decision to fetch.
module unidade_de_desvio
   import unidade_de_desvio_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             flagWrite_i,
   input  logic             zero_i,
   input  logic             overflow_i,
   input  logic             negative_i,
   input  logic             flagBusy_i,
   input  logic             branchValid_i,
   output logic             branchReady_o,
   input  logic [2:0]       branchCond_i,
   input  logic [WIDTH-1:0] branchTarget_i,
   input  logic             flush_i,
   output logic             takeValid_o,
   input  logic             takeReady_i,
   output logic             takeBranch_o,
   output logic [WIDTH-1:0] targetOut_o,
   output logic [2:0]       flags_o
);

   state_t           state_q, state_d;
   logic [2:0]       flags_q;
   logic [2:0]       cond_q;
   logic [WIDTH-1:0] target_q;
   logic             takeValid_q, takeValid_d;
   logic             takeBranch_q, takeBranch_d;
   logic [WIDTH-1:0] targetOut_q, targetOut_d;
   logic             accept;
   logic             flushActive;
   logic             evalTaken;

   avaliador_de_condicao uAvaliador (
      .flags_i (flags_q),
      .cond_i  (cond_q),
      .taken_o (evalTaken)
   );

   assign flushActive = flush_i && (state_q != ST_IDLE);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (branchValid_i) state_d = flagBusy_i ? ST_WAIT : ST_EVAL;
         ST_WAIT: if (flagWrite_i || !flagBusy_i) state_d = ST_EVAL;
         ST_EVAL: state_d = ST_HOLD;
         ST_HOLD: if (takeReady_i) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      if (flushActive) state_d = ST_IDLE;
   end

   // A flush clears the valid but leaves the last decision/target visible.
   always_comb begin
      branchReady_o = (state_q == ST_IDLE);
      accept        = branchValid_i && (state_q == ST_IDLE);
      takeValid_d   = takeValid_q;
      takeBranch_d  = takeBranch_q;
      targetOut_d   = targetOut_q;
      if (flushActive) begin
         takeValid_d = 1'b0;
      end else if (state_q == ST_EVAL) begin
         takeValid_d  = 1'b1;
         takeBranch_d = evalTaken;
         targetOut_d  = target_q;
      end else if (state_q == ST_HOLD && takeReady_i) begin
         takeValid_d = 1'b0;
      end
   end

   // Flag writes land in every state, independent of the FSM and of flush.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         flags_q      <= 3'b000;
         cond_q       <= COND_AL;
         target_q     <= '0;
         takeValid_q  <= 1'b0;
         takeBranch_q <= 1'b0;
         targetOut_q  <= '0;
      end else begin
         if (flagWrite_i) flags_q <= {negative_i, overflow_i, zero_i};
         if (accept) begin
            cond_q   <= branchCond_i;
            target_q <= branchTarget_i;
         end
         takeValid_q  <= takeValid_d;
         takeBranch_q <= takeBranch_d;
         targetOut_q  <= targetOut_d;
      end
   end

   assign takeValid_o  = takeValid_q;
   assign takeBranch_o = takeBranch_q;
   assign targetOut_o  = targetOut_q;
   assign flags_o      = flags_q;

endmodule

// File: tb/tb_unidade_de_desvio.sv
// Self-checking bench for unidade_de_desvio: directed scenarios followed by
// a condition sweep and randomized branches against a behavioural model.
module tb_unidade_de_desvio;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        flagWrite_i, zero_i, overflow_i, negative_i, flagBusy_i;
   logic        branchValid_i, branchReady_o;
   logic [2:0]  branchCond_i;
   logic [31:0] branchTarget_i;
   logic        flush_i, takeValid_o, takeReady_i, takeBranch_o;
   logic [31:0] targetOut_o;
   logic [2:0]  flags_o;

   int          testCount = 0;
   int          failCount = 0;
   logic [2:0]  mFlags;

   unidade_de_desvio #(.WIDTH(32)) dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .flagWrite_i    (flagWrite_i),
      .zero_i         (zero_i),
      .overflow_i     (overflow_i),
      .negative_i     (negative_i),
      .flagBusy_i     (flagBusy_i),
      .branchValid_i  (branchValid_i),
      .branchReady_o  (branchReady_o),
      .branchCond_i   (branchCond_i),
      .branchTarget_i (branchTarget_i),
      .flush_i        (flush_i),
      .takeValid_o    (takeValid_o),
      .takeReady_i    (takeReady_i),
      .takeBranch_o   (takeBranch_o),
      .targetOut_o    (targetOut_o),
      .flags_o        (flags_o)
   );

   // Free-running 10-time-unit clock.
   always #5 clk_i = ~clk_i;

   // Condition table: bit index is the condition code.
   function automatic logic expTaken(input logic [2:0] cond, input logic [2:0] nvz);
      logic       n, v, z;
      logic [7:0] tbl;
      n   = nvz[2];
      v   = nvz[1];
      z   = nvz[0];
      tbl = {1'b0, ~v, v, (n == v), (n != v), ~z, z, 1'b1};
      return tbl[cond];
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic fw, input logic [2:0] nvz, input logic busy,
                                input logic bv, input logic [2:0] cond, input logic [31:0] tgt,
                                input logic fl, input logic rdy);
      flagWrite_i    = fw;
      negative_i     = nvz[2];
      overflow_i     = nvz[1];
      zero_i         = nvz[0];
      flagBusy_i     = busy;
      branchValid_i  = bv;
      branchCond_i   = cond;
      branchTarget_i = tgt;
      flush_i        = fl;
      takeReady_i    = rdy;
   endtask

   // Advances one clock edge, tracking the flag register in the model.
   task automatic tick();
      if (rst_ni && flagWrite_i) mFlags = {negative_i, overflow_i, zero_i};
      @(posedge clk_i);
      #1;
   endtask

   task automatic idleInputs();
      applyStimulus(1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 32'h0, 1'b0, 1'b0);
   endtask

   // Stimulus and checks, run as one linear sequence.
   initial begin
      logic [2:0]  rCond, rNvz, snapFlags;
      logic [31:0] rTgt, snapTarget;
      logic        rBusy, rExp, snapBranch;
      int          nWait, nDelay;

      rst_ni = 1'b0;
      mFlags = 3'b000;
      idleInputs();
      #12;
      rst_ni = 1'b1;
      tick();
      checkOutput("reset ready", 32'(branchReady_o), 32'd1);
      checkOutput("reset valid", 32'(takeValid_o), 32'd0);
      checkOutput("reset branch", 32'(takeBranch_o), 32'd0);
      checkOutput("reset target", targetOut_o, 32'd0);
      checkOutput("reset flags", 32'(flags_o), 32'd0);

      // EQ taken, no hazard
      applyStimulus(1'b1, 3'b001, 1'b0, 1'b0, 3'b000, 32'h0, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, 3'b000, 1'b0, 1'b1, 3'b001, 32'h40, 1'b0, 1'b0);
      tick();
      idleInputs();
      checkOutput("eq ready low", 32'(branchReady_o), 32'd0);
      checkOutput("eq valid early", 32'(takeValid_o), 32'd0);
      tick();
      checkOutput("eq valid", 32'(takeValid_o), 32'd1);
      checkOutput("eq branch", 32'(takeBranch_o), 32'd1);
      checkOutput("eq target", targetOut_o, 32'h40);
      applyStimulus(1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 32'h0, 1'b0, 1'b1);
      tick();
      idleInputs();
      checkOutput("eq release valid", 32'(takeValid_o), 32'd0);
      checkOutput("eq release ready", 32'(branchReady_o), 32'd1);

      // Hazard: LT waits on an in-flight flag writer
      applyStimulus(1'b1, 3'b000, 1'b0, 1'b0, 3'b000, 32'h0, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, 3'b000, 1'b1, 1'b1, 3'b011, 32'h80, 1'b0, 1'b0);
      tick();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 3'b000, 1'b1, 1'b0, 3'b000, 32'h0, 1'b0, 1'b0);
         tick();
         checkOutput($sformatf("hazard wait valid %0d", i), 32'(takeValid_o), 32'd0);
         checkOutput($sformatf("hazard wait ready %0d", i), 32'(branchReady_o), 32'd0);
      end
      applyStimulus(1'b1, 3'b100, 1'b0, 1'b0, 3'b000, 32'h0, 1'b0, 1'b0);
      tick();
      idleInputs();
      checkOutput("hazard valid at write edge", 32'(takeValid_o), 32'd0);
      tick();
      checkOutput("hazard valid", 32'(takeValid_o), 32'd1);
      checkOutput("hazard branch", 32'(takeBranch_o), 32'd1);
      checkOutput("hazard target", targetOut_o, 32'h80);
      applyStimulus(1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 32'h0, 1'b0, 1'b1);
      tick();
      idleInputs();

      // Back-pressure: flag write coinciding with accept, then HOLD for 5 cycles
      applyStimulus(1'b1, 3'b001, 1'b0, 1'b1, 3'b001, 32'hC0, 1'b0, 1'b0);
      tick();
      idleInputs();
      tick();
      checkOutput("bp valid", 32'(takeValid_o), 32'd1);
      checkOutput("bp branch", 32'(takeBranch_o), 32'd1);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, {2'b00, i[0]}, 1'b0, 1'b0, 3'b000, 32'h0, 1'b0, 1'b0);
         tick();
         checkOutput($sformatf("bp hold valid %0d", i), 32'(takeValid_o), 32'd1);
         checkOutput($sformatf("bp hold branch %0d", i), 32'(takeBranch_o), 32'd1);
         checkOutput($sformatf("bp hold target %0d", i), targetOut_o, 32'hC0);
         checkOutput($sformatf("bp hold ready %0d", i), 32'(branchReady_o), 32'd0);
         checkOutput($sformatf("bp hold flags %0d", i), 32'(flags_o), 32'(mFlags));
      end
      applyStimulus(1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 32'h0, 1'b0, 1'b1);
      tick();
      idleInputs();
      checkOutput("bp release valid", 32'(takeValid_o), 32'd0);
      checkOutput("bp release ready", 32'(branchReady_o), 32'd1);

      // Flush during WAIT, then flush in IDLE is ignored
      applyStimulus(1'b0, 3'b000, 1'b1, 1'b1, 3'b001, 32'h100, 1'b0, 1'b0);
      tick();
      snapFlags = mFlags;
      applyStimulus(1'b0, 3'b000, 1'b1, 1'b0, 3'b000, 32'h0, 1'b0, 1'b0);
      tick();
      checkOutput("flush wait ready", 32'(branchReady_o), 32'd0);
      applyStimulus(1'b0, 3'b000, 1'b1, 1'b0, 3'b000, 32'h0, 1'b1, 1'b0);
      tick();
      idleInputs();
      checkOutput("flush ready", 32'(branchReady_o), 32'd1);
      checkOutput("flush valid", 32'(takeValid_o), 32'd0);
      for (int i = 0; i < 2; i++) begin
         tick();
         checkOutput($sformatf("flush no pulse %0d", i), 32'(takeValid_o), 32'd0);
      end
      checkOutput("flush flags", 32'(flags_o), 32'(snapFlags));
      checkOutput("flush keeps target", targetOut_o, 32'hC0);
      applyStimulus(1'b0, 3'b000, 1'b0, 1'b1, 3'b000, 32'h200, 1'b1, 1'b0);
      tick();
      idleInputs();
      checkOutput("idle flush accept", 32'(branchReady_o), 32'd0);
      tick();
      checkOutput("idle flush valid", 32'(takeValid_o), 32'd1);
      checkOutput("idle flush target", targetOut_o, 32'h200);
      applyStimulus(1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 32'h0, 1'b0, 1'b1);
      tick();
      idleInputs();

      // Sweep all conditions against all flag combinations
      for (int c = 0; c < 8; c++) begin
         for (int f = 0; f < 8; f++) begin
            applyStimulus(1'b1, f[2:0], 1'b0, 1'b0, 3'b000, 32'h0, 1'b0, 1'b0);
            tick();
            applyStimulus(1'b0, 3'b000, 1'b0, 1'b1, c[2:0], 32'(c * 16 + f), 1'b0, 1'b0);
            tick();
            idleInputs();
            tick();
            checkOutput($sformatf("sweep c%0d f%0d", c, f), 32'(takeBranch_o), 32'(expTaken(c[2:0], f[2:0])));
            applyStimulus(1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 32'h0, 1'b0, 1'b1);
            tick();
            idleInputs();
         end
      end

      // Randomized branches with random hazards, flag writes and back-pressure
      for (int k = 0; k < 40; k++) begin
         rCond = 3'($urandom_range(0, 7));
         rNvz  = 3'($urandom_range(0, 7));
         rBusy = 1'($urandom_range(0, 1));
         rTgt  = $urandom;
         applyStimulus(1'($urandom_range(0, 1)), rNvz, rBusy, 1'b1, rCond, rTgt, 1'b0, 1'b0);
         tick();
         if (rBusy) begin
            nWait = $urandom_range(0, 3);
            repeat (nWait) begin
               applyStimulus(1'b0, 3'($urandom_range(0, 7)), 1'b1, 1'b0, 3'b000, 32'h0, 1'b0, 1'b0);
               tick();
            end
            if ($urandom_range(0, 1) == 1)
               applyStimulus(1'b1, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b0, 3'b000, 32'h0, 1'b0, 1'b0);
            else
               applyStimulus(1'b0, 3'($urandom_range(0, 7)), 1'b0, 1'b0, 3'b000, 32'h0, 1'b0, 1'b0);
            tick();
         end
         rExp = expTaken(rCond, mFlags);
         applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'b0, 1'b0, 3'b000, 32'h0, 1'b0, 1'b0);
         checkOutput($sformatf("rnd%0d eval valid", k), 32'(takeValid_o), 32'd0);
         tick();
         checkOutput($sformatf("rnd%0d valid", k), 32'(takeValid_o), 32'd1);
         checkOutput($sformatf("rnd%0d branch", k), 32'(takeBranch_o), 32'(rExp));
         checkOutput($sformatf("rnd%0d target", k), targetOut_o, rTgt);
         nDelay = $urandom_range(0, 2);
         repeat (nDelay) begin
            applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'b0, 1'b0, 3'b000, 32'h0, 1'b0, 1'b0);
            tick();
            checkOutput($sformatf("rnd%0d hold branch", k), 32'(takeBranch_o), 32'(rExp));
         end
         applyStimulus(1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 32'h0, 1'b0, 1'b1);
         tick();
         idleInputs();
         checkOutput($sformatf("rnd%0d release", k), 32'(takeValid_o), 32'd0);
         checkOutput($sformatf("rnd%0d flags", k), 32'(flags_o), 32'(mFlags));
      end

      // Asynchronous reset in the middle of HOLD
      applyStimulus(1'b1, 3'b111, 1'b0, 1'b1, 3'b000, 32'h300, 1'b0, 1'b0);
      tick();
      idleInputs();
      tick();
      checkOutput("pre-reset valid", 32'(takeValid_o), 32'd1);
      snapBranch = takeBranch_o;
      snapTarget = targetOut_o;
      checkOutput("pre-reset target", snapTarget, 32'h300);
      #2;
      rst_ni = 1'b0;
      mFlags = 3'b000;
      #1;
      checkOutput("async reset valid", 32'(takeValid_o), 32'd0);
      checkOutput("async reset flags", 32'(flags_o), 32'd0);
      checkOutput("async reset ready", 32'(branchReady_o), 32'd1);
      checkOutput("async reset branch", 32'(takeBranch_o), 32'd0);
      checkOutput("async reset target", targetOut_o, 32'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      tick();
      checkOutput("post-reset ready", 32'(branchReady_o), 32'd1);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
